aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_if.sv | 32 +++
 rtl/aes_round_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Key-install and block-handshake bundle between the AES round controller and its host/datapath.
// slave: the controller side; master: the host/datapath side.
interface aes_round_ctrl_if;
    logic [255:0] key_i;
    logic         key_load_i;
    logic         key_busy_o;
    logic [255:0] kx_key_o;
    logic         kx_key_valid_o;
    logic         kx_keys_valid_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic         round_en_o;
    logic [3:0]   round_idx_o;
    logic         round_first_o;
    logic         round_last_o;
    logic         blk_done_o;
    logic         err_o;

    modport slave (
        input  key_i, key_load_i, kx_keys_valid_i, blk_valid_i,
        output key_busy_o, kx_key_o, kx_key_valid_o, blk_ready_o,
               round_en_o, round_idx_o, round_first_o, round_last_o,
               blk_done_o, err_o
    );

    modport master (
        output key_i, key_load_i, kx_keys_valid_i, blk_valid_i,
        input  key_busy_o, kx_key_o, kx_key_valid_o, blk_ready_o,
               round_en_o, round_idx_o, round_first_o, round_last_o,
               blk_done_o, err_o
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-256 round sequencer: key install through the expansion block, then 15 rounds per block.
// Optional AES_KEY_CACHE_EN: a reload of the already-installed key in READY is absorbed.
module aes_round_ctrl #(
    parameter int unsigned KX_TIMEOUT = 128
) (
    input  logic             clk,
    input  logic             resetn,
    aes_round_ctrl_if.slave  bus
);
    localparam int unsigned KEY_W    = 256;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = 14;
    localparam int unsigned DROP_CYC = 2;
    localparam int unsigned CNT_W    = $clog2(KX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DROP, S_KX_REQ, S_READY, S_ROUND, S_ERR
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [KEY_W-1:0]   r_key;
    logic               r_pend;
    logic               r_err;
    logic               r_done;
    logic               r_busy;
    logic               r_kxv;
    logic               r_en;
    logic               r_first;
    logic               r_last;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [KEY_W-1:0]   w_key_nxt;
    logic               w_pend_nxt;
    logic               w_err_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;
    logic               w_kxv_nxt;
    logic               w_en_nxt;
    logic               w_first_nxt;
    logic               w_last_nxt;
    logic               w_same_key;
    logic               w_blk_ready;

`ifdef AES_KEY_CACHE_EN
    assign w_same_key = (bus.key_i == r_key);
`else
    assign w_same_key = 1'b0;
`endif

    // A block is only taken when no key load competes and the round keys are still valid.
    assign w_blk_ready = (r_state == S_READY) && !bus.key_load_i && bus.kx_keys_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_key_nxt   = r_key;
        w_pend_nxt  = r_pend;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.key_load_i) begin
                    w_key_nxt   = bus.key_i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (r_cnt == CNT_W'(DROP_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_KX_REQ;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_KX_REQ: begin
                if (bus.kx_keys_valid_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_READY;
                end else if (r_cnt == CNT_W'(KX_TIMEOUT - 1)) begin
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_READY: begin
                if (bus.key_load_i) begin
                    if (!w_same_key) begin
                        w_key_nxt   = bus.key_i;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DROP;
                    end
                end else if (!bus.kx_keys_valid_i) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (bus.blk_valid_i) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                // A mid-block key load is deferred; the running block keeps its round keys.
                if (bus.key_load_i) begin
                    w_key_nxt  = bus.key_i;
                    w_pend_nxt = 1'b1;
                end
                if (r_idx == IDX_W'(LAST_IDX)) begin
                    w_done_nxt = 1'b1;
                    w_idx_nxt  = '0;
                    if (r_pend || bus.key_load_i) begin
                        w_pend_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_state_nxt = S_READY;
                    end
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_ERR: begin
                if (bus.key_load_i) begin
                    w_key_nxt   = bus.key_i;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DROP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt  = (w_state_nxt == S_DROP) || (w_state_nxt == S_KX_REQ);
        w_kxv_nxt   = (w_state_nxt == S_KX_REQ) || (w_state_nxt == S_READY) ||
                      (w_state_nxt == S_ROUND);
        w_en_nxt    = (w_state_nxt == S_ROUND);
        w_first_nxt = w_en_nxt && (w_idx_nxt == IDX_W'(0));
        w_last_nxt  = w_en_nxt && (w_idx_nxt == IDX_W'(LAST_IDX));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_key   <= '0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_kxv   <= 1'b0;
            r_en    <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_key   <= w_key_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_kxv   <= w_kxv_nxt;
            r_en    <= w_en_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.key_busy_o     = r_busy;
    assign bus.kx_key_o       = r_key;
    assign bus.kx_key_valid_o = r_kxv;
    assign bus.blk_ready_o    = w_blk_ready;
    assign bus.round_en_o     = r_en;
    assign bus.round_idx_o    = r_idx;
    assign bus.round_first_o  = r_first;
    assign bus.round_last_o   = r_last;
    assign bus.blk_done_o     = r_done;
    assign bus.err_o          = r_err;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl; build with AES_KEY_CACHE_EN to exercise key reload absorption.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [255:0] K0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K1 = {8{32'hdeadbeef}};
    localparam logic [255:0] K2 = {8{32'h01234567}};
    localparam logic [255:0] K3 = {8{32'hcafef00d}};

    typedef struct {
        logic        bv;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [33];

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.KX_TIMEOUT(128)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic busy, input logic kxv, input logic rdy,
                                       input logic en, input logic [3:0] idx, input logic first,
                                       input logic last, input logic done, input logic err);
        return {busy, kxv, rdy, en, idx, first, last, done, err};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.key_busy_o, bus.kx_key_valid_o, bus.blk_ready_o, bus.round_en_o,
                bus.round_idx_o, bus.round_first_o, bus.round_last_o, bus.blk_done_o, bus.err_o};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic kl, input logic bv, input logic kv);
        @(negedge clk);
        bus.key_load_i      = kl;
        bus.blk_valid_i     = bv;
        bus.kx_keys_valid_i = kv;
        #1;
    endtask

    task automatic install(input logic [255:0] k, input int kv_delay, input string tag);
        bus.key_i = k;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk({tag, " drop1"}, 256'(outs()), 256'(mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 0)));
        cyc(1'b0, 1'b0, 1'b0);
        chk({tag, " drop2"}, 256'(outs()), 256'(mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 0)));
        cyc(1'b0, 1'b0, 1'b0);
        chk({tag, " kxreq"}, 256'(outs()), 256'(mk(1, 1, 0, 0, 4'd0, 0, 0, 0, 0)));
        chk({tag, " kxkey"}, bus.kx_key_o, k);
        repeat (kv_delay) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk({tag, " ready"}, 256'(outs()), 256'(mk(0, 1, 1, 0, 4'd0, 0, 0, 0, 0)));
    endtask

    initial begin
        logic seen_done;

        // Two back-to-back blocks: handshakes at k=0 and k=16, done pulses at k=16 and k=32.
        for (int k = 0; k < 33; k++) begin
            tbl[k].bv = (k == 0) || (k == 16);
            if (k == 0)
                tbl[k].exp = mk(0, 1, 1, 0, 4'd0, 0, 0, 0, 0);
            else if (k == 16 || k == 32)
                tbl[k].exp = mk(0, 1, 1, 0, 4'd0, 0, 0, 1, 0);
            else if (k < 16)
                tbl[k].exp = mk(0, 1, 0, 1, 4'(k - 1), k == 1, k == 15, 0, 0);
            else
                tbl[k].exp = mk(0, 1, 0, 1, 4'(k - 17), k == 17, k == 31, 0, 0);
        end

        resetn              = 1'b0;
        bus.key_i           = '0;
        bus.key_load_i      = 1'b0;
        bus.blk_valid_i     = 1'b0;
        bus.kx_keys_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset outs", 256'(outs()), 256'(0));
        chk("reset key", bus.kx_key_o, 256'(0));
        @(negedge clk);
        resetn = 1'b1;

        install(K0, 59, "boot");

        for (int k = 0; k < 33; k++) begin
            cyc(1'b0, tbl[k].bv, 1'b1);
            chk($sformatf("b2b k%0d", k), 256'(outs()), 256'(tbl[k].exp));
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b idle", 256'(outs()), 256'(mk(0, 1, 1, 0, 4'd0, 0, 0, 0, 0)));

        // Key load at round index 5 is deferred to the end of the block.
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 1; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            chk($sformatf("mid k%0d", k), 256'(outs()),
                256'(mk(0, 1, 0, 1, 4'(k - 1), k == 1, 0, 0, 0)));
        end
        bus.key_i = K2;
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid load idx5", 256'(outs()), 256'(mk(0, 1, 0, 1, 4'd5, 0, 0, 0, 0)));
        for (int k = 7; k < 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("mid k%0d", k), 256'(outs()),
                256'(mk(0, 1, 0, 1, 4'(k - 1), 0, k == 15, 0, 0)));
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("mid done drop", 256'(outs()), 256'(mk(1, 0, 0, 0, 4'd0, 0, 0, 1, 0)));
        cyc(1'b0, 1'b0, 1'b0);
        chk("mid drop2", 256'(outs()), 256'(mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 0)));
        cyc(1'b0, 1'b0, 1'b0);
        chk("mid kxreq", 256'(outs()), 256'(mk(1, 1, 0, 0, 4'd0, 0, 0, 0, 0)));
        chk("mid kxkey", bus.kx_key_o, K2);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("mid ready", 256'(outs()), 256'(mk(0, 1, 1, 0, 4'd0, 0, 0, 0, 0)));

        // Same key reloaded in READY together with a block offer: load wins.
        bus.key_i = K2;
`ifdef AES_KEY_CACHE_EN
        cyc(1'b1, 1'b1, 1'b1);
        chk("reload rdy low", 256'(outs()), 256'(mk(0, 1, 0, 0, 4'd0, 0, 0, 0, 0)));
        cyc(1'b0, 1'b0, 1'b1);
        chk("reload absorbed", 256'(outs()), 256'(mk(0, 1, 1, 0, 4'd0, 0, 0, 0, 0)));
        bus.key_i = K3;
        cyc(1'b1, 1'b0, 1'b0);
`else
        cyc(1'b1, 1'b1, 1'b0);
        chk("reload rdy low", 256'(outs()), 256'(mk(0, 1, 0, 0, 4'd0, 0, 0, 0, 0)));
`endif
        cyc(1'b0, 1'b0, 1'b0);
        chk("reload drop1", 256'(outs()), 256'(mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 0)));
        cyc(1'b0, 1'b0, 1'b0);
        chk("reload drop2", 256'(outs()), 256'(mk(1, 0, 0, 0, 4'd0, 0, 0, 0, 0)));
        cyc(1'b0, 1'b0, 1'b0);
        chk("reload kxreq", 256'(outs()), 256'(mk(1, 1, 0, 0, 4'd0, 0, 0, 0, 0)));

        // Expansion never answers: ERR after exactly 128 cycles in KX_REQ.
        for (int i = 1; i < 128; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (i == 127)
                chk("timeout last kx", 256'(outs()), 256'(mk(1, 1, 0, 0, 4'd0, 0, 0, 0, 0)));
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("timeout err", 256'(outs()), 256'(mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1)));
        cyc(1'b0, 1'b0, 1'b0);
        chk("err sticky", 256'(outs()), 256'(mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1)));
        install(K1, 3, "recover");

        // Expanded keys vanish while READY.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("kv drop err", 256'(outs()), 256'(mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1)));
        install(K2, 0, "recover2");

        // Reset in the middle of a block.
        cyc(1'b0, 1'b1, 1'b1);
        repeat (7) cyc(1'b0, 1'b0, 1'b1);
        chk("pre-reset idx6", 256'(outs()), 256'(mk(0, 1, 0, 1, 4'd6, 0, 0, 0, 0)));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid-round reset outs", 256'(outs()), 256'(0));
        chk("mid-round reset key", bus.kx_key_o, 256'(0));
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done |= bus.blk_done_o;
        end
        resetn = 1'b1;
        repeat (16) begin
            cyc(1'b0, 1'b0, 1'b1);
            seen_done |= bus.blk_done_o;
        end
        chk("no done after reset", 256'(seen_done), 256'(0));
        chk("idle after reset", 256'(outs()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
